keypad_scanner: RTL and testbench

- Input-side counterpart of the multiplexed 7-segment output path on the Basys3 board.
- The display block drives one digit at a time. This block drives one keypad column at a time and samples the rows of an external 4x4 hex keypad.
- Row readings are debounced across full scans. Each accepted press becomes a 4-bit key code with a one-cycle valid strobe, for the CPU data path or the display select logic.
- Runs on the 100 MHz board clock.

---
 rtl/keypad_scanner_if.sv | 25 ++
 rtl/keypad_scanner.sv | 189 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad-side bundle: column drive out, row sense in, plus the decoded key event.
// The scanner uses the slave modport; whatever owns the keypad uses master.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport slave (
        input  row,
        output col,
        output key_code,
        output key_valid,
        output key_held
    );

    modport master (
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: one active-low column at a time, rows sampled once per column window,
// full-scan snapshots debounced by a four-state FSM into a key code, a one-cycle valid pulse and a held flag.
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    keypad_scanner_if.slave  kp
);

    localparam int              DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]      DEB_MAX  = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    logic [3:0]       row_meta_reg;
    logic [3:0]       row_sync_reg;
    logic [DIV_W-1:0] div_reg;
    logic [1:0]       col_idx_reg;
    logic [15:0]      snapshot_reg;

    state_t           state_reg,    state_next;
    logic [3:0]       cnt_reg,      cnt_next;
    logic [3:0]       pending_reg,  pending_next;
    logic [3:0]       key_code_reg, key_code_next;
    logic             key_valid_reg, key_valid_next;
    logic             key_held_reg, key_held_next;

    logic             div_last;
    logic             scan_end;
    logic [15:0]      snap_full;
    logic [4:0]       ones;
    logic [3:0]       cand_code;
    logic             cand_valid;
    logic             cand_none;
    logic [3:0]       cnt_inc;

    assign div_last = (div_reg == DIV_LAST);
    assign scan_end = div_last && (col_idx_reg == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_reg <= 4'b1111;
            row_sync_reg <= 4'b1111;
            div_reg      <= '0;
            col_idx_reg  <= '0;
            snapshot_reg <= '0;
        end else begin
            row_meta_reg <= kp.row;
            row_sync_reg <= row_meta_reg;
            if (div_last) begin
                div_reg     <= '0;
                col_idx_reg <= col_idx_reg + 2'd1;
                // Stored inverted so a set bit means "pressed" at position {col, row}.
                snapshot_reg[col_idx_reg*4 +: 4] <= ~row_sync_reg;
            end else begin
                div_reg <= div_reg + DIV_W'(1);
            end
        end
    end

    // Column 3's sample is still in flight at scan end, so merge it in directly.
    always_comb begin
        snap_full        = snapshot_reg;
        snap_full[15:12] = ~row_sync_reg;
        ones             = '0;
        cand_code        = '0;
        for (int i = 0; i < 16; i++) begin
            if (snap_full[i]) begin
                ones      = ones + 5'd1;
                cand_code = 4'(i);
            end
        end
    end

    assign cand_valid = (ones == 5'd1);
    assign cand_none  = (ones == 5'd0);
    assign cnt_inc    = (cnt_reg >= DEB_MAX) ? DEB_MAX : cnt_reg + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            pending_reg   <= '0;
            key_code_reg  <= '0;
            key_valid_reg <= 1'b0;
            key_held_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            pending_reg   <= pending_next;
            key_code_reg  <= key_code_next;
            key_valid_reg <= key_valid_next;
            key_held_reg  <= key_held_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        pending_next   = pending_reg;
        key_code_next  = key_code_reg;
        key_valid_next = 1'b0;
        key_held_next  = key_held_reg;

        if (scan_end) begin
            unique case (state_reg)
                IDLE: begin
                    if (cand_valid) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_next     = HELD;
                            key_code_next  = cand_code;
                            key_valid_next = 1'b1;
                            key_held_next  = 1'b1;
                            cnt_next       = '0;
                        end else begin
                            state_next   = DEBOUNCE;
                            pending_next = cand_code;
                            cnt_next     = 4'd1;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (cand_valid && cand_code == pending_reg) begin
                        if (cnt_inc >= DEB_MAX) begin
                            state_next     = HELD;
                            key_code_next  = pending_reg;
                            key_valid_next = 1'b1;
                            key_held_next  = 1'b1;
                            cnt_next       = '0;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end else if (cand_valid) begin
                        pending_next = cand_code;
                        cnt_next     = 4'd1;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end
                HELD: begin
                    // Other keys and ghosting are ignored until a clean release.
                    if (cand_none) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_next    = IDLE;
                            key_held_next = 1'b0;
                            cnt_next      = '0;
                        end else begin
                            state_next = RELEASE;
                            cnt_next   = 4'd1;
                        end
                    end
                end
                RELEASE: begin
                    if (cand_none) begin
                        if (cnt_inc >= DEB_MAX) begin
                            state_next    = IDLE;
                            key_held_next = 1'b0;
                            cnt_next      = '0;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end else begin
                        state_next = HELD;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign kp.col       = ~(4'b0001 << col_idx_reg);
    assign kp.key_code  = key_code_reg;
    assign kp.key_valid = key_valid_reg;
    assign kp.key_held  = key_held_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=8, DEBOUNCE_SCANS=2: a keypad model closes
// rows against the driven column; stimulus changes only at scan boundaries (32 cycles).
module tb_keypad_scanner;

    localparam int SCAN = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] press_mask = '0;
    int          total = 0;
    int          bad = 0;
    int          valid_count = 0;

    keypad_scanner_if kp_if();

    keypad_scanner #(.SCAN_DIV(8), .DEBOUNCE_SCANS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp_if)
    );

    always #5 clk = ~clk;

    // Keypad model: a pressed key at {c, r} pulls row r low while column c is driven low.
    always_comb begin
        kp_if.row = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (press_mask[c*4 + r] && kp_if.col[c] == 1'b0) kp_if.row[r] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && kp_if.key_valid === 1'b1) valid_count = valid_count + 1;
    end

    // Waits whole scans from a scan-aligned negedge, then settles past the monitor.
    task automatic wait_scans(input int n);
        #(-1 + 1);
        repeat (n * SCAN) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (kp_if.col !== 4'b1110) begin bad++; $display("FAIL reset_col: got %b want 1110", kp_if.col); end
        total++; if (kp_if.key_code !== 4'h0) begin bad++; $display("FAIL reset_code: got %h want 0", kp_if.key_code); end
        total++; if (kp_if.key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", kp_if.key_valid); end
        total++; if (kp_if.key_held !== 1'b0) begin bad++; $display("FAIL reset_held: got %b want 0", kp_if.key_held); end
        rst_n = 1'b1;
        $display("test_reset: col=%b code=%h held=%b", kp_if.col, kp_if.key_code, kp_if.key_held);
    endtask

    task automatic test_idle_scan();
        logic [3:0] col_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        valid_count = 0;
        // Starts on the reset-release negedge, where the divider is 0 in column 0.
        for (int i = 0; i < 2 * SCAN; i++) begin
            total++;
            if (kp_if.col !== col_tab[(i / 8) % 4]) begin
                bad++; $display("FAIL idle_col[%0d]: got %b want %b", i, kp_if.col, col_tab[(i / 8) % 4]);
            end
            @(negedge clk);
        end
        #1;
        total++; if (valid_count != 0) begin bad++; $display("FAIL idle_valid: got %0d pulses want 0", valid_count); end
        total++; if (kp_if.key_code !== 4'h0) begin bad++; $display("FAIL idle_code: got %h want 0", kp_if.key_code); end
        total++; if (kp_if.key_held !== 1'b0) begin bad++; $display("FAIL idle_held: got %b want 0", kp_if.key_held); end
        $display("test_idle_scan: pulses=%0d", valid_count);
    endtask

    task automatic test_press_9();
        valid_count = 0;
        press_mask = 16'h0200;
        wait_scans(1);
        total++; if (kp_if.key_held !== 1'b0) begin bad++; $display("FAIL p9_held_early: got %b want 0", kp_if.key_held); end
        wait_scans(1);
        total++; if (kp_if.key_held !== 1'b1) begin bad++; $display("FAIL p9_held: got %b want 1", kp_if.key_held); end
        total++; if (kp_if.key_code !== 4'h9) begin bad++; $display("FAIL p9_code: got %h want 9", kp_if.key_code); end
        total++; if (valid_count != 1) begin bad++; $display("FAIL p9_pulse: got %0d pulses want 1", valid_count); end
        wait_scans(1);
        press_mask = '0;
        wait_scans(1);
        total++; if (kp_if.key_held !== 1'b1) begin bad++; $display("FAIL p9_held_rel1: got %b want 1", kp_if.key_held); end
        wait_scans(1);
        total++; if (kp_if.key_held !== 1'b0) begin bad++; $display("FAIL p9_held_rel2: got %b want 0", kp_if.key_held); end
        total++; if (valid_count != 1) begin bad++; $display("FAIL p9_pulse_total: got %0d pulses want 1", valid_count); end
        total++; if (kp_if.key_code !== 4'h9) begin bad++; $display("FAIL p9_code_kept: got %h want 9", kp_if.key_code); end
        $display("test_press_9: code=%h pulses=%0d", kp_if.key_code, valid_count);
    endtask

    task automatic test_short_press();
        valid_count = 0;
        press_mask = 16'h0040;
        wait_scans(1);
        press_mask = '0;
        wait_scans(2);
        total++; if (valid_count != 0) begin bad++; $display("FAIL short_pulse: got %0d pulses want 0", valid_count); end
        total++; if (kp_if.key_held !== 1'b0) begin bad++; $display("FAIL short_held: got %b want 0", kp_if.key_held); end
        press_mask = 16'h0001;
        wait_scans(3);
        total++; if (valid_count != 1) begin bad++; $display("FAIL key0_pulse: got %0d pulses want 1", valid_count); end
        total++; if (kp_if.key_code !== 4'h0) begin bad++; $display("FAIL key0_code: got %h want 0", kp_if.key_code); end
        total++; if (kp_if.key_held !== 1'b1) begin bad++; $display("FAIL key0_held: got %b want 1", kp_if.key_held); end
        press_mask = '0;
        wait_scans(2);
        total++; if (kp_if.key_held !== 1'b0) begin bad++; $display("FAIL key0_release: got %b want 0", kp_if.key_held); end
        $display("test_short_press: code=%h pulses=%0d", kp_if.key_code, valid_count);
    endtask

    task automatic test_multi();
        valid_count = 0;
        press_mask = 16'h0090;
        wait_scans(5);
        total++; if (valid_count != 0) begin bad++; $display("FAIL multi_pulse: got %0d pulses want 0", valid_count); end
        total++; if (kp_if.key_held !== 1'b0) begin bad++; $display("FAIL multi_held: got %b want 0", kp_if.key_held); end
        press_mask = '0;
        wait_scans(1);
        $display("test_multi: pulses=%0d", valid_count);
    endtask

    task automatic test_release_bounce();
        valid_count = 0;
        press_mask = 16'h0020;
        wait_scans(3);
        total++; if (kp_if.key_code !== 4'h5) begin bad++; $display("FAIL bounce_code: got %h want 5", kp_if.key_code); end
        press_mask = '0;
        wait_scans(1);
        total++; if (kp_if.key_held !== 1'b1) begin bad++; $display("FAIL bounce_held_a: got %b want 1", kp_if.key_held); end
        press_mask = 16'h0020;
        wait_scans(1);
        total++; if (kp_if.key_held !== 1'b1) begin bad++; $display("FAIL bounce_held_b: got %b want 1", kp_if.key_held); end
        press_mask = '0;
        wait_scans(1);
        total++; if (kp_if.key_held !== 1'b1) begin bad++; $display("FAIL bounce_held_c: got %b want 1", kp_if.key_held); end
        wait_scans(1);
        total++; if (kp_if.key_held !== 1'b0) begin bad++; $display("FAIL bounce_held_d: got %b want 0", kp_if.key_held); end
        total++; if (valid_count != 1) begin bad++; $display("FAIL bounce_pulse: got %0d pulses want 1", valid_count); end
        $display("test_release_bounce: code=%h pulses=%0d", kp_if.key_code, valid_count);
    endtask

    task automatic test_reset_mid_debounce();
        valid_count = 0;
        press_mask = 16'h0400;
        wait_scans(1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (kp_if.col !== 4'b1110) begin bad++; $display("FAIL rst_mid_col: got %b want 1110", kp_if.col); end
        total++; if (kp_if.key_held !== 1'b0) begin bad++; $display("FAIL rst_mid_held: got %b want 0", kp_if.key_held); end
        total++; if (kp_if.key_code !== 4'h0) begin bad++; $display("FAIL rst_mid_code: got %h want 0", kp_if.key_code); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_scans(1);
        total++; if (valid_count != 0) begin bad++; $display("FAIL rst_mid_pulse: got %0d pulses want 0", valid_count); end
        total++; if (kp_if.key_held !== 1'b0) begin bad++; $display("FAIL rst_mid_restart: got %b want 0", kp_if.key_held); end
        wait_scans(1);
        total++; if (valid_count != 1) begin bad++; $display("FAIL rst_mid_press: got %0d pulses want 1", valid_count); end
        total++; if (kp_if.key_code !== 4'hA) begin bad++; $display("FAIL rst_mid_code2: got %h want a", kp_if.key_code); end
        press_mask = '0;
        wait_scans(2);
        total++; if (kp_if.key_held !== 1'b0) begin bad++; $display("FAIL rst_mid_release: got %b want 0", kp_if.key_held); end
        $display("test_reset_mid_debounce: code=%h pulses=%0d", kp_if.key_code, valid_count);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_idle_scan();
        test_press_9();
        test_short_press();
        test_multi();
        test_release_bounce();
        test_reset_mid_debounce();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
